// File: rtl/detector_secuencia_pkg.sv
// Shared constants, state names and the elaboration-time next-state
// generator for the serial pattern detector.
package detector_pkg;

    localparam int PAT_LEN = 4;
    localparam int ST_W    = 3;

    localparam logic [PAT_LEN-1:0] PATRON_DEF = 4'b1101;

    // Sk: the longest prefix of the pattern that ends the accepted stream has length k.
    typedef enum logic [ST_W-1:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } estado_t;

    // Next state for state k and input bit b: the longest prefix of pat that is
    // a suffix of (prefix(k) followed by b). Pattern MSB is the first bit received.
    function automatic logic [ST_W-1:0] kmp_next(input logic [PAT_LEN-1:0] pat,
                                                 input int                 k,
                                                 input logic               b);
        logic [ST_W-1:0] best;
        logic            ok;
        logic            sbit;
        int              p;
        best = '0;
        for (int j = 1; j <= PAT_LEN; j++) begin
            if (j <= k + 1) begin
                ok = 1'b1;
                for (int i = 0; i < j; i++) begin
                    p = k + 1 - j + i;
                    if (p == k) begin
                        sbit = b;
                    end else begin
                        sbit = pat[PAT_LEN-1-p];
                    end
                    if (pat[PAT_LEN-1-i] != sbit) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    best = ST_W'(j);
                end
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/detector_secuencia_if.sv
// Serial stream input and result outputs of the pattern detector.
interface detector_secuencia_if #(
    parameter int CNT_W = 8
);
    import detector_pkg::*;

    logic             din;
    logic             din_valid;
    logic             clear_cnt;
    logic             match;
    logic [CNT_W-1:0] cnt;
    logic             rise;
    logic             fall;
    logic [ST_W-1:0]  estado;

    modport master (
        output din, din_valid, clear_cnt,
        input  match, cnt, rise, fall, estado
    );

    modport slave (
        input  din, din_valid, clear_cnt,
        output match, cnt, rise, fall, estado
    );

endinterface

// File: rtl/detector_secuencia_flancos.sv
// Edge detector on the accepted bit stream: remembers the last accepted bit
// and pulses rise/fall for one cycle when an accepted bit differs from it.
module detector_flancos (
    input  logic clk,
    input  logic reset,
    input  logic din_i,
    input  logic din_valid_i,
    output logic rise_o,
    output logic fall_o
);

    logic prev_q, prev_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Compare the incoming bit with the previous accepted one; idle cycles hold prev.
    always_comb begin
        prev_d = prev_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (din_valid_i) begin
            prev_d = din_i;
            rise_d = din_i & ~prev_q;
            fall_d = ~din_i & prev_q;
        end
    end

    // Register prev and the one-cycle pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/detector_secuencia.sv
// Overlapping 4-bit serial pattern detector with registered match pulse,
// saturating match counter and edge flags on the accepted stream.
module detector_secuencia
    import detector_pkg::*;
#(
    parameter logic [PAT_LEN-1:0] PATRON = PATRON_DEF,
    parameter int                 CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    detector_secuencia_if.slave   bus
);

    estado_t          state_q, state_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Transition table derived from the pattern at elaboration time.
    logic [ST_W-1:0] ns_tab [0:PAT_LEN][0:1];

    genvar gi, gb;
    generate
        for (gi = 0; gi <= PAT_LEN; gi++) begin : g_state
            for (gb = 0; gb < 2; gb++) begin : g_bit
                assign ns_tab[gi][gb] = kmp_next(PATRON, gi, 1'(gb));
            end
        end
    endgenerate

    // Next state, match pulse and counter update; clear beats a same-cycle increment.
    always_comb begin
        state_d = state_q;
        match_d = 1'b0;
        cnt_d   = cnt_q;
        if (bus.din_valid) begin
            state_d = estado_t'(ns_tab[int'(state_q)][bus.din]);
            match_d = (state_d == S4);
        end
        if (bus.clear_cnt) begin
            cnt_d = '0;
        end else if (match_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State, match and counter registers; reset discards any partial prefix.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S0;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
        end
    end

    detector_flancos u_flancos (
        .clk         (clk),
        .reset       (reset),
        .din_i       (bus.din),
        .din_valid_i (bus.din_valid),
        .rise_o      (bus.rise),
        .fall_o      (bus.fall)
    );

    assign bus.match  = match_q;
    assign bus.cnt    = cnt_q;
    assign bus.estado = state_q;

endmodule
